register_file_2r1w: RTL and testbench

- 32-entry x 32-bit general-purpose register file with two read ports and one write port, for the processor datapath.
- R0 is hardwired to zero.
- Reads and writes are gated by a 2-bit enable, `read_or_write`.
- Read data is registered, so results appear on the clock edge after the request.

---
 rtl/register_file_2r1w.sv | 105 ++++++++++
 tb/tb_register_file_2r1w.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// ---------------------------------------------------------------------------
// register_file_2r1w
//
// Purpose:
//   General-purpose register file for the processor datapath. It has
//   2**ADDR_WIDTH entries of DATA_WIDTH bits, two registered read ports and
//   one write port. R0 is hardwired to zero.
//
// Optional feature:
//   REGFILE_WRITE_BYPASS_EN - when defined, a read and a write on the same
//   edge to the same non-zero address forward write_data to that read port.
//   When undefined, the read returns the old register contents.
//
// Ports:
//   clk           in   system clock, rising edge active
//   rst           in   asynchronous active-low reset (0 = clear everything)
//   read_or_write in   [1] read enable, [0] write enable
//   read_addr_1   in   register index for read port 1
//   read_addr_2   in   register index for read port 2
//   write_addr    in   register index for the write port
//   write_data    in   data to write
//   read_data_1   out  registered read result, port 1
//   read_data_2   out  registered read result, port 2
// ---------------------------------------------------------------------------
module register_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            read_or_write,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  read_en;
    logic                  write_en;
    logic                  write_hits_reg;
    logic [DATA_WIDTH-1:0] next_read_1;
    logic [DATA_WIDTH-1:0] next_read_2;

    assign read_en        = read_or_write[1];
    assign write_en       = read_or_write[0];
    // Writes to R0 are dropped so the entry stays zero forever.
    assign write_hits_reg = write_en && (write_addr != '0);

    // Value a read port will capture on the coming edge. Address 0 is
    // forced to zero explicitly rather than relying on the R0 storage.
    function automatic logic [DATA_WIDTH-1:0] lookup(
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr != '0) begin
            value = regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
            // Forward the in-flight write so the reader sees the new value.
            if (write_hits_reg && (addr == write_addr)) begin
                value = write_data;
            end
`endif
        end
        return value;
    endfunction

    always_comb begin
        next_read_1 = '0;
        next_read_2 = '0;
        if (read_en) begin
            next_read_1 = lookup(read_addr_1);
            next_read_2 = lookup(read_addr_2);
        end
    end

    // Register array storage; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hits_reg) begin
            regs[write_addr] <= write_data;
        end
    end

    // Registered read outputs; a disabled read drives zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_1 <= '0;
            read_data_2 <= '0;
        end else begin
            read_data_1 <= next_read_1;
            read_data_2 <= next_read_2;
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// ---------------------------------------------------------------------------
// tb_register_file_2r1w
//
// Purpose:
//   Self-checking bench for register_file_2r1w. Directed vectors are issued
//   on the falling edge together with their hand-computed expected outputs,
//   which go into a queue. A monitor pops one entry after every rising edge
//   that follows an issued vector and compares both read ports. Asynchronous
//   reset behaviour is checked directly between clock edges.
//
// Build option:
//   REGFILE_WRITE_BYPASS_EN selects the forwarding expectations.
// ---------------------------------------------------------------------------
module tb_register_file_2r1w;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [1:0]    read_or_write;
    logic [AW-1:0] read_addr_1;
    logic [AW-1:0] read_addr_2;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data_1;
    logic [DW-1:0] read_data_2;

    typedef struct {
        int            id;
        logic [DW-1:0] exp_1;
        logic [DW-1:0] exp_2;
    } expect_t;

    expect_t expect_q[$];
    int      tests_run;
    int      tests_failed;
    int      vec_id;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    register_file_2r1w #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .read_or_write(read_or_write),
        .read_addr_1  (read_addr_1),
        .read_addr_2  (read_addr_2),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2)
    );

    // 10 time-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison with failure reporting.
    task automatic check_output(input string name, input logic [DW-1:0] actual,
                                input logic [DW-1:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Issue one vector on the falling edge and record what the next rising
    // edge must produce on both read ports.
    task automatic apply_stimulus(input logic [1:0] rw, input logic [AW-1:0] ra1,
                                  input logic [AW-1:0] ra2, input logic [AW-1:0] wa,
                                  input logic [DW-1:0] wd, input logic [DW-1:0] e1,
                                  input logic [DW-1:0] e2);
        expect_t item;
        @(negedge clk);
        read_or_write = rw;
        read_addr_1   = ra1;
        read_addr_2   = ra2;
        write_addr    = wa;
        write_data    = wd;
        item.id    = vec_id;
        item.exp_1 = e1;
        item.exp_2 = e2;
        expect_q.push_back(item);
        vec_id++;
    endtask

    // Wait until the monitor has consumed every queued expectation.
    task automatic drain_queue();
        int budget;
        budget = 0;
        while (expect_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            #2;
            budget++;
        end
        if (expect_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expect_q.size());
            expect_q.delete();
        end
    endtask

    // Monitor: compare outputs just after each rising edge that has a
    // pending expectation.
    initial begin
        expect_t item;
        forever begin
            @(posedge clk);
            #1;
            if (expect_q.size() != 0) begin
                item = expect_q.pop_front();
                check_output($sformatf("vec%0d_rd1", item.id), read_data_1, item.exp_1);
                check_output($sformatf("vec%0d_rd2", item.id), read_data_2, item.exp_2);
            end
        end
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        vec_id        = 0;
        rst           = 1'b0;
        read_or_write = 2'b00;
        read_addr_1   = '0;
        read_addr_2   = '0;
        write_addr    = '0;
        write_data    = '0;

        #1;
        check_output("reset_rd1", read_data_1, 32'h0);
        check_output("reset_rd2", read_data_2, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset.
        apply_stimulus(2'b00, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Port 1 write path: read-only does not write, write-only reads zero.
        apply_stimulus(2'b10, 5'd1, 5'd31, 5'd1, 32'hF0F0F0F0, 32'h0, 32'h0);
        apply_stimulus(2'b01, 5'd1, 5'd31, 5'd1, 32'hF0F0F0F0, 32'h0, 32'h0);
        apply_stimulus(2'b10, 5'd1, 5'd31, 5'd1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0);

        // Port 2 write path on the top register.
        apply_stimulus(2'b10, 5'd1, 5'd31, 5'd31, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0);
        apply_stimulus(2'b01, 5'd1, 5'd31, 5'd31, 32'h0F0F0F0F, 32'h0, 32'h0);
        apply_stimulus(2'b10, 5'd1, 5'd31, 5'd31, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0F0F0F0F);

        // R0 cannot be written or forwarded.
        apply_stimulus(2'b11, 5'd0, 5'd0, 5'd0, 32'h0F0F0F0F, 32'h0, 32'h0);
        apply_stimulus(2'b11, 5'd0, 5'd0, 5'd0, 32'h0F0F0F0F, 32'h0, 32'h0);
        apply_stimulus(2'b10, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Both ports on the same register.
        apply_stimulus(2'b10, 5'd31, 5'd31, 5'd0, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0F);
        apply_stimulus(2'b10, 5'd1, 5'd1, 5'd0, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0);

        // Leave nonzero outputs, then assert reset between edges.
        apply_stimulus(2'b10, 5'd1, 5'd31, 5'd0, 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F);
        drain_queue();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("async_rst_rd1", read_data_1, 32'h0);
        check_output("async_rst_rd2", read_data_2, 32'h0);
        @(posedge clk);
        #1;
        check_output("held_rst_rd1", read_data_1, 32'h0);
        check_output("held_rst_rd2", read_data_2, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Every register must read back zero after reset.
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(2'b10, 5'(i), 5'(31 - i), 5'd0, 32'h0, 32'h0, 32'h0);
        end

        // Simultaneous read and write on the same address.
        apply_stimulus(2'b01, 5'd0, 5'd0, 5'd5, 32'hAAAA5555, 32'h0, 32'h0);
        apply_stimulus(2'b11, 5'd5, 5'd5, 5'd5, 32'h12345678,
                       BYPASS ? 32'h12345678 : 32'hAAAA5555,
                       BYPASS ? 32'h12345678 : 32'hAAAA5555);
        apply_stimulus(2'b10, 5'd5, 5'd0, 5'd0, 32'h0, 32'h12345678, 32'h0);

        // Forwarding applies only to the port whose address matches.
        apply_stimulus(2'b11, 5'd7, 5'd5, 5'd7, 32'hDEADBEEF,
                       BYPASS ? 32'hDEADBEEF : 32'h0, 32'h12345678);
        apply_stimulus(2'b10, 5'd5, 5'd7, 5'd0, 32'h0, 32'h12345678, 32'hDEADBEEF);

        // Write-only with read disabled drives zeros, then read back.
        apply_stimulus(2'b01, 5'd7, 5'd5, 5'd9, 32'hCAFEF00D, 32'h0, 32'h0);
        apply_stimulus(2'b10, 5'd9, 5'd7, 5'd0, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF);
        apply_stimulus(2'b00, 5'd9, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0);

        drain_queue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
